// File: rtl/axis_uart_cfg_pkg.sv
// rtl/axis_uart_cfg_pkg.sv - shared constants, FSM state types and divider helper for axis_uart_cfg
package axis_uart_cfg_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int TUSER_PERR = 0;
    localparam int TUSER_FERR = 1;

    // TX_LOAD holds the accepted byte until the first tick so the start bit is tick-aligned
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic int calc_div(input longint clock, input longint baud);
        return int'((clock + baud * 8) / (baud * 16));
    endfunction

endpackage

// File: rtl/axis_uart_cfg_baud.sv
// rtl/axis_uart_cfg_baud.sv - free-running 16x oversample tick generator shared by TX and RX
module axis_uart_cfg_baud #(
    parameter int DIV = 1
) (
    input  logic aclk,
    input  logic areset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/axis_uart_cfg.sv
// rtl/axis_uart_cfg.sv - configurable AXI-Stream UART, 16x oversampled RX with status on tuser
// Optional internal TX->RX loopback port enabled by AXIS_UART_LOOPBACK_EN.
module axis_uart_cfg
    import axis_uart_cfg_pkg::*;
#(
    parameter int CLOCK     = 100_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 aclk,
    input  logic                 areset,
`ifdef AXIS_UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [1:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 rx_overrun,
    output logic                 tx_busy
);

    localparam int DIV = calc_div(CLOCK, BAUD_RATE);
    localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY == PARITY_ODD);
    localparam bit         HAS_PAR   = (PARITY != PARITY_NONE);

    if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_cfg_error
        $error("axis_uart_cfg: illegal configuration");
    end

    logic tick;

    axis_uart_cfg_baud #(.DIV(DIV)) u_baud (
        .aclk   (aclk),
        .areset (areset),
        .tick   (tick)
    );

    logic lb;
`ifdef AXIS_UART_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    // ---------------- TX ----------------
    tx_state_e           tx_state_q, tx_state_d;
    logic [4:0]          tx_cnt_q, tx_cnt_d;
    logic [3:0]          tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                tx_par_q, tx_par_d;
    logic                tx_q, tx_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_rdy_q, tx_rdy_d;
    logic                tx_hs;

    assign s_axis_tready = tx_rdy_q & ~areset;
    assign tx_hs         = s_axis_tvalid & s_axis_tready;
    assign tx_busy       = tx_busy_q | tx_hs;
    assign uart_tx       = lb ? 1'b1 : tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_rdy_d   = tx_rdy_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_rdy_d = 1'b1;
                if (tx_hs) begin
                    tx_shreg_d = s_axis_tdata;
                    tx_par_d   = (^s_axis_tdata) ^ PAR_ODD;
                    tx_state_d = TX_LOAD;
                    tx_rdy_d   = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            TX_LOAD: begin
                if (tick) begin
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_cnt_q == 5'd15) begin
                        tx_cnt_d   = '0;
                        tx_bit_d   = '0;
                        tx_d       = tx_shreg_q[0];
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 5'd1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_cnt_q == 5'd15) begin
                        tx_cnt_d = '0;
                        if (tx_bit_q == BIT_LAST) begin
                            tx_d       = HAS_PAR ? tx_par_q : 1'b1;
                            tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_bit_d   = tx_bit_q + 4'd1;
                            tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
                            tx_d       = tx_shreg_q[1];
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + 5'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    if (tx_cnt_q == 5'd15) begin
                        tx_cnt_d   = '0;
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 5'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_cnt_q == STOP_LAST) begin
                        tx_cnt_d   = '0;
                        tx_busy_d  = 1'b0;
                        tx_rdy_d   = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 5'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_rdy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_rdy_q   <= tx_rdy_d;
        end
    end

    // ---------------- RX ----------------
    logic                 rx_in;
    logic                 rx_s1_q, rx_s1_d;
    logic                 rx_s2_q, rx_s2_d;
    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
    logic                 rx_perr_q, rx_perr_d;
    logic [DATA_BITS-1:0] m_tdata_q, m_tdata_d;
    logic [1:0]           m_tuser_q, m_tuser_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_done_c;
    logic                 rx_ferr_c;

    assign rx_in         = lb ? tx_q : uart_rx;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign rx_overrun    = ovr_q;

    always_comb begin
        rx_s1_d    = rx_in;
        rx_s2_d    = rx_s1_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shreg_d = rx_shreg_q;
        rx_perr_d  = rx_perr_q;
        rx_done_c  = 1'b0;
        rx_ferr_c  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_perr_d  = 1'b0;
                        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_shreg_d = {rx_s2_q, rx_shreg_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_LAST) begin
                            rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 4'd1;
                        end
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_perr_d  = rx_s2_q ^ (^rx_shreg_q) ^ PAR_ODD;
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    // only the first stop bit is checked; we leave before it ends
                    if (rx_cnt_q == 4'd15) begin
                        rx_done_c  = 1'b1;
                        rx_ferr_c  = ~rx_s2_q;
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tuser_d  = m_tuser_q;
        m_tvalid_d = m_tvalid_q;
        ovr_d      = 1'b0;
        if (rx_done_c) begin
            if (!m_tvalid_q || m_axis_tready) begin
                m_tdata_d             = rx_shreg_q;
                m_tuser_d[TUSER_PERR] = rx_perr_q;
                m_tuser_d[TUSER_FERR] = rx_ferr_c;
                m_tvalid_d            = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (m_tvalid_q && m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shreg_q <= '0;
            rx_perr_q  <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= '0;
            m_tvalid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shreg_q <= rx_shreg_d;
            rx_perr_q  <= rx_perr_d;
            m_tdata_q  <= m_tdata_d;
            m_tuser_q  <= m_tuser_d;
            m_tvalid_q <= m_tvalid_d;
            ovr_q      <= ovr_d;
        end
    end

endmodule

// File: tb/tb_axis_uart_cfg.sv
// tb/tb_axis_uart_cfg.sv - directed bench for axis_uart_cfg (8N1 and 7E1 instances, AXIS_UART_LOOPBACK_EN aware)
module tb_axis_uart_cfg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rx8 = 1'b1, tx8, s_tvalid8 = 1'b0, s_tready8, m_tvalid8, m_tready8 = 1'b0, ovr8, busy8;
    logic [7:0] s_tdata8 = 8'h00, m_tdata8;
    logic [1:0] m_tuser8;

    logic       rx7 = 1'b1, tx7, s_tvalid7 = 1'b0, s_tready7, m_tvalid7, m_tready7 = 1'b0, ovr7, busy7;
    logic [6:0] s_tdata7 = 7'h00, m_tdata7;
    logic [1:0] m_tuser7;

    int ovr_cnt8 = 0;
    always @(negedge clk) if (ovr8) ovr_cnt8++;

`ifdef AXIS_UART_LOOPBACK_EN
    logic lb8 = 1'b0;
    int   tx_low_lb = 0;
    always @(negedge clk) if (lb8 && tx8 !== 1'b1) tx_low_lb++;
`endif

    axis_uart_cfg #(.CLOCK(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8 (
        .aclk(clk), .areset(rst),
`ifdef AXIS_UART_LOOPBACK_EN
        .loopback(lb8),
`endif
        .uart_rx(rx8), .uart_tx(tx8),
        .s_axis_tdata(s_tdata8), .s_axis_tvalid(s_tvalid8), .s_axis_tready(s_tready8),
        .m_axis_tdata(m_tdata8), .m_axis_tuser(m_tuser8), .m_axis_tvalid(m_tvalid8), .m_axis_tready(m_tready8),
        .rx_overrun(ovr8), .tx_busy(busy8)
    );

    axis_uart_cfg #(.CLOCK(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u7 (
        .aclk(clk), .areset(rst),
`ifdef AXIS_UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .uart_rx(rx7), .uart_tx(tx7),
        .s_axis_tdata(s_tdata7), .s_axis_tvalid(s_tvalid7), .s_axis_tready(s_tready7),
        .m_axis_tdata(m_tdata7), .m_axis_tuser(m_tuser7), .m_axis_tvalid(m_tvalid7), .m_axis_tready(m_tready7),
        .rx_overrun(ovr7), .tx_busy(busy7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drives a 10-bit line frame LSB first, 16 clocks per bit; optional one-cycle tready pulse on u8
    task automatic drive_rx(input int sel, input logic [15:0] bits, input int hs_at);
        for (int n = 0; n < 160; n++) begin
            if (n % 16 == 0) begin
                if (sel == 8) rx8 = bits[n / 16];
                else          rx7 = bits[n / 16];
            end
            if (n == hs_at)     m_tready8 = 1'b1;
            if (n == hs_at + 1) m_tready8 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic consume8();
        m_tready8 = 1'b1;
        @(negedge clk);
        m_tready8 = 1'b0;
        chk("consume8_tvalid", 32'(m_tvalid8), 0);
    endtask

    task automatic consume7();
        m_tready7 = 1'b1;
        @(negedge clk);
        m_tready7 = 1'b0;
        chk("consume7_tvalid", 32'(m_tvalid7), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] tx_exp;
        int base;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 32'(tx8), 1);
        chk("rst_tready", 32'(s_tready8), 0);
        chk("rst_tvalid", 32'(m_tvalid8), 0);
        chk("rst_tdata", 32'(m_tdata8), 0);
        chk("rst_tuser", 32'(m_tuser8), 0);
        chk("rst_overrun", 32'(ovr8), 0);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_uart_tx7", 32'(tx7), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tready", 32'(s_tready8), 1);

        // TX 0xA5, 8N1
        s_tdata8  = 8'hA5;
        s_tvalid8 = 1'b1;
        #1;
        chk("tx_busy_hs_cycle", 32'(busy8), 1);
        @(negedge clk);
        s_tvalid8 = 1'b0;
        chk("tx_tready_drop", 32'(s_tready8), 0);
        chk("tx_wait_tick", 32'(tx8), 1);
        @(negedge clk);
        tx_exp = {1'b1, 8'hA5, 1'b0};
        for (int off = 0; off < 160; off++) begin
            if (off % 16 == 0 || off % 16 == 15) chk("tx_bit", 32'(tx8), 32'(tx_exp[off / 16]));
            if (off == 159) chk("tx_tready_in_stop", 32'(s_tready8), 0);
            @(negedge clk);
        end
        chk("tx_tready_after_stop", 32'(s_tready8), 1);
        chk("tx_busy_after_stop", 32'(busy8), 0);
        chk("tx_idle_high", 32'(tx8), 1);

        // 7E1 receive: correct parity, then wrong parity
        drive_rx(7, {6'b0, 1'b1, 1'b0, 7'h55, 1'b0}, -10);
        chk("rx7_tvalid_a", 32'(m_tvalid7), 1);
        chk("rx7_tdata_a", 32'(m_tdata7), 32'h55);
        chk("rx7_tuser_a", 32'(m_tuser7), 0);
        consume7();
        drive_rx(7, {6'b0, 1'b1, 1'b1, 7'h55, 1'b0}, -10);
        chk("rx7_tvalid_b", 32'(m_tvalid7), 1);
        chk("rx7_tdata_b", 32'(m_tdata7), 32'h55);
        chk("rx7_tuser_b", 32'(m_tuser7), 1);
        consume7();

        // 8N1 framing error
        drive_rx(8, {6'b0, 1'b0, 8'h3C, 1'b0}, -10);
        rx8 = 1'b1;
        chk("ferr_tvalid", 32'(m_tvalid8), 1);
        chk("ferr_tdata", 32'(m_tdata8), 32'h3C);
        chk("ferr_tuser", 32'(m_tuser8), 2);
        consume8();
        repeat (30) @(negedge clk);
        chk("ferr_no_false_frame", 32'(m_tvalid8), 0);

        // overrun: second frame dropped while first is held
        base = ovr_cnt8;
        drive_rx(8, {6'b0, 1'b1, 8'h11, 1'b0}, -10);
        drive_rx(8, {6'b0, 1'b1, 8'h22, 1'b0}, -10);
        chk("ovr_tdata_held", 32'(m_tdata8), 32'h11);
        chk("ovr_tvalid", 32'(m_tvalid8), 1);
        chk("ovr_pulses", 32'(ovr_cnt8 - base), 1);

        // handshake in the completion cycle: new frame loads, no overrun
        base = ovr_cnt8;
        drive_rx(8, {6'b0, 1'b1, 8'h33, 1'b0}, 154);
        chk("simul_tdata", 32'(m_tdata8), 32'h33);
        chk("simul_tvalid", 32'(m_tvalid8), 1);
        chk("simul_tuser", 32'(m_tuser8), 0);
        chk("simul_no_ovr", 32'(ovr_cnt8 - base), 0);
        consume8();

        // glitch rejection
        rx8 = 1'b0;
        repeat (4) @(negedge clk);
        rx8 = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_tvalid", 32'(m_tvalid8), 0);

        // reset in the middle of a TX frame
        s_tdata8  = 8'h00;
        s_tvalid8 = 1'b1;
        @(negedge clk);
        s_tvalid8 = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_tx_line_low", 32'(tx8), 0);
        chk("mid_tx_busy", 32'(busy8), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_uart_tx", 32'(tx8), 1);
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_tready", 32'(s_tready8), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_tready_back", 32'(s_tready8), 1);

`ifdef AXIS_UART_LOOPBACK_EN
        lb8 = 1'b1;
        base = tx_low_lb;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h81;
            s_tdata8  = b;
            s_tvalid8 = 1'b1;
            @(negedge clk);
            s_tvalid8 = 1'b0;
            for (int n = 0; n < 300 && !m_tvalid8; n++) @(negedge clk);
            chk("lb_tvalid", 32'(m_tvalid8), 1);
            chk("lb_tdata", 32'(m_tdata8), 32'(b));
            chk("lb_tuser", 32'(m_tuser8), 0);
            consume8();
            for (int n = 0; n < 60 && !s_tready8; n++) @(negedge clk);
            chk("lb_tready_back", 32'(s_tready8), 1);
        end
        chk("lb_uart_tx_high", 32'(tx_low_lb - base), 0);
        lb8 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_uart_cfg.md
Name: axis_uart_cfg

Overview:
Configurable AXI-Stream UART and successor to the fixed 8N1 UART pair. Frame format is set at elaboration: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits. RX uses a 16x oversampled receiver with mid-bit sampling. RX status (parity/framing error, overrun) travels with the data on tuser and a sticky-free pulse. Sits between AXIS fabric logic and the board UART pins.

Parameters:
CLOCK, 100_000_000, aclk frequency in Hz
BAUD_RATE, 115_200, line rate in bit/s
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits, legal 1 or 2

Ports:
aclk  in  1  system clock
areset  in  1  reset; one clock; reset is synchronous and active-high
uart_rx  in  1  asynchronous serial input
uart_tx  out  1  serial output, idle high
s_axis_tdata  in  DATA_BITS  byte to transmit
s_axis_tvalid  in  1  TX data valid
s_axis_tready  out  1  TX accepts data
m_axis_tdata  out  DATA_BITS  received data
m_axis_tuser  out  2  [0] parity error, [1] framing error
m_axis_tvalid  out  1  RX data valid
m_axis_tready  in  1  downstream accepts
rx_overrun  out  1  one-cycle pulse: frame lost
tx_busy  out  1  high while a TX frame is on the line

Behaviour:
- Reset values: uart_tx=1, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, rx_overrun=0, tx_busy=0. Both FSMs go to IDLE. The divider and bit counters clear. Reset mid-frame aborts immediately and uart_tx returns high in the next cycle.
- Tick generator: DIV = round(CLOCK / (BAUD_RATE*16)). A single free-running counter produces a 1-cycle tick every DIV clocks. Elaboration fails if DIV < 1, or if DATA_BITS, PARITY, or STOP_BITS is illegal.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE. Each state lasts 16 ticks; STOP lasts 16*STOP_BITS ticks.
- TX handshake and timing:
  - s_axis_tready=1 only in IDLE with areset low.
  - On a handshake, data is latched and tready drops the next cycle.
  - uart_tx goes low on the first tick after the handshake.
  - Data is sent LSB first. Parity bit: even = XOR of data bits; odd = its inverse.
  - tx_busy=1 from the handshake cycle through the end of STOP.
- RX input: uart_rx passes through a 2-flop synchronizer. IDLE waits for the synchronized line to be low on a tick.
- RX FSM: START counts 8 ticks and resamples the line.
  - Resample high -> false start, return to IDLE with no output.
  - Resample low -> DATA: sample every 16 ticks at mid-bit, LSB first. Then PARITY if enabled, then STOP, sampled once at the mid-point of the first stop bit only.
- RX result: parity_err = received parity ≠ computed parity. frame_err = stop sample low. After the stop sample, the FSM returns to IDLE (it does not wait for the stop bit to end).
- RX output: a single output register.
  - On frame completion with m_axis_tvalid=0: load tdata and tuser, assert tvalid next cycle.
  - With tvalid=1 already: the new frame is dropped, the register is unchanged, and rx_overrun pulses 1 cycle.
  - tvalid holds until the m_axis_tvalid&&m_axis_tready cycle and clears the following cycle.
  - Completion and handshake in the same cycle: the new frame loads and tvalid stays 1; no overrun.
  - Frames with errors are still delivered; tuser flags them.
- When DATA_BITS<8 the top bits simply do not exist; no padding.

Optional Feature:
AXIS_UART_LOOPBACK_EN: when defined, adds an input port loopback (1 bit). When loopback=1, the RX synchronizer input is the internal TX serial line instead of uart_rx, and uart_tx is held high. When the macro is undefined, the port is absent and RX always uses uart_rx.

Decomposition:
- Package axis_uart_cfg_pkg:
  - PARITY_NONE/ODD/EVEN localparams
  - TX and RX state enums
  - function calc_div(CLOCK,BAUD)
  - tuser bit index constants
- Sub-modules:
  - axis_uart_cfg_baud: tick generator, one instance shared by TX and RX.
  - TX and RX FSMs stay in the top module.

Test Plan:
- CLOCK=16_000_000, BAUD=1_000_000, 8N1. Send 0xA5 on s_axis -> uart_tx low 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk; tready returns 1 after STOP.
- DATA_BITS=7, PARITY=2 (even). Drive a line frame of 0x55 with parity bit 0 -> m_axis_tdata=0x55, tuser=00. Repeat with parity bit 1 -> tuser=01.
- 8N1 frame 0x3C with stop bit held low -> tdata=0x3C, tuser=10.
- Hold m_axis_tready=0 and send 0x11 then 0x22 -> tdata stays 0x11 and rx_overrun pulses once. Raise tready with a frame completing in the same cycle -> no overrun, next tdata is the new frame.
- 4-clk low glitch on uart_rx -> no m_axis_tvalid. Assert areset mid-TX-frame -> uart_tx=1 and tx_busy=0 on the next cycle.
- With AXIS_UART_LOOPBACK_EN and loopback=1: send 0x00, 0xFF, 0x81 -> identical bytes on m_axis, tuser=00, uart_tx constantly 1.
